spw_tx_host_feeder: RTL and testbench

SPW_TX_HOST_FEEDER -- requirements
Module: spw_tx_host_feeder

---
 rtl/spw_tx_host_feeder_pkg.sv | 22 ++
 rtl/spw_tx_host_feeder_timecode.sv | 42 ++++
 rtl/spw_tx_host_feeder.sv | 165 ++++++++++++++++
 tb/tb_spw_tx_host_feeder.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spw_tx_host_feeder_pkg.sv
// Shared types and constants for the SpaceWire TX host feeder: FSM state
// encoding, control-word markers and counter widths.
package spw_tx_host_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_XFER    = 2'd1,
    ST_TERM    = 2'd2,
    ST_DISCARD = 2'd3
  } feeder_state_e;

  localparam logic [8:0] SPW_EOP = 9'h100;
  localparam logic [8:0] SPW_EEP = 9'h101;

  localparam int BYTE_CNT_W = 16;
  localparam int STAT_CNT_W = 16;

  function automatic logic [8:0] spw_marker(input logic eep);
    return eep ? SPW_EEP : SPW_EOP;
  endfunction

endpackage

// File: rtl/spw_tx_host_feeder_timecode.sv
// Time-code scheduler: latches one pending request and emits a single-cycle
// tick carrying the 6-bit counter when the transmitter and link are ready.
module spw_timecode_sched #(
  parameter int TIME_INIT = 0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_req_i,
  input  logic       ready_tick_i,
  input  logic       link_run_i,
  output logic       tick_o,
  output logic [7:0] time_o
);

  localparam logic [5:0] CNT_INIT = 6'(TIME_INIT);

  logic       pending_q, pending_d;
  logic [5:0] cnt_q, cnt_d;
  logic       fire;

  assign fire = pending_q & ready_tick_i & link_run_i;

  // A request arriving while one is already pending is absorbed.
  always_comb begin
    pending_d = fire ? 1'b0 : (pending_q | tick_req_i);
    cnt_d     = fire ? (cnt_q + 6'd1) : cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= 1'b0;
      cnt_q     <= CNT_INIT;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign tick_o = fire;
  assign time_o = {2'b00, cnt_q};

endmodule

// File: rtl/spw_tx_host_feeder.sv
// Host-to-TX-FIFO packet feeder with EOP/EEP termination, overflow and
// link-loss discard; optional time-code path enabled by SPW_TX_TIMECODE_EN.
module spw_tx_host_feeder
  import spw_tx_host_feeder_pkg::*;
#(
  parameter int MAX_PKT_LEN = 4096,
  parameter int TIME_INIT   = 0
) (
  input  logic                  CLOCK,
  input  logic                  RESETn,
  input  logic                  host_valid,
  input  logic [7:0]            host_data,
  input  logic                  host_last,
  input  logic                  host_err,
  output logic                  host_ready,
  input  logic                  link_run,
  input  logic                  f_full,
  output logic                  top_tx_write,
  output logic [8:0]            top_tx_data,
  input  logic                  tick_req,
  input  logic                  top_tx_ready_tick,
  output logic                  top_tx_tick,
  output logic [7:0]            top_tx_time,
  output logic [STAT_CNT_W-1:0] pkt_count,
  output logic [STAT_CNT_W-1:0] abort_count,
  output feeder_state_e         dbg_state_o
);

  localparam logic [BYTE_CNT_W-1:0] MAX_LEN = BYTE_CNT_W'(MAX_PKT_LEN);

  // Handshake: a host beat transfers on a rising CLOCK edge where
  // host_valid && host_ready; host_ready never depends on host_valid.

  feeder_state_e         state_q, state_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_inc;
  logic                  eep_q, eep_d;
  logic                  forced_q, forced_d;
  logic [STAT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [STAT_CNT_W-1:0] abort_cnt_q, abort_cnt_d;
  logic                  beat_acc;

  assign beat_acc     = host_valid & host_ready;
  assign byte_cnt_inc = byte_cnt_q + 1'b1;

  always_ff @(posedge CLOCK or negedge RESETn) begin : fsm_reg
    if (!RESETn) begin
      state_q     <= ST_IDLE;
      byte_cnt_q  <= '0;
      eep_q       <= 1'b0;
      forced_q    <= 1'b0;
      pkt_cnt_q   <= '0;
      abort_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      eep_q       <= eep_d;
      forced_q    <= forced_d;
      pkt_cnt_q   <= pkt_cnt_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  always_comb begin : fsm_next
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    eep_d       = eep_q;
    forced_d    = forced_q;
    pkt_cnt_d   = pkt_cnt_q;
    abort_cnt_d = abort_cnt_q;
    case (state_q)
      ST_IDLE, ST_XFER: begin
        if (state_q == ST_IDLE) begin
          byte_cnt_d = '0;
        end
        if (state_q == ST_XFER && !link_run) begin
          state_d     = ST_DISCARD;
          byte_cnt_d  = '0;
          abort_cnt_d = abort_cnt_q + 1'b1;
        end else if (beat_acc) begin
          byte_cnt_d = byte_cnt_inc;
          if (host_last) begin
            state_d  = ST_TERM;
            eep_d    = host_err;
            forced_d = 1'b0;
          end else if (byte_cnt_inc == MAX_LEN) begin
            // Length limit hit mid-packet: terminate now, drop the remainder.
            state_d  = ST_TERM;
            eep_d    = 1'b1;
            forced_d = 1'b1;
          end else begin
            state_d = ST_XFER;
          end
        end
      end
      ST_TERM: begin
        if (!f_full) begin
          state_d    = forced_q ? ST_DISCARD : ST_IDLE;
          byte_cnt_d = '0;
          eep_d      = 1'b0;
          forced_d   = 1'b0;
          pkt_cnt_d  = pkt_cnt_q + 1'b1;
        end
      end
      ST_DISCARD: begin
        byte_cnt_d = '0;
        if (host_valid && host_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are forced low while RESETn is asserted so nothing leaks out
  // during reset even though host_ready is combinational.
  always_comb begin : fsm_out
    host_ready   = 1'b0;
    top_tx_write = 1'b0;
    top_tx_data  = '0;
    if (RESETn) begin
      case (state_q)
        ST_IDLE, ST_XFER: begin
          host_ready = link_run & ~f_full;
          if (host_valid && link_run && !f_full) begin
            top_tx_write = 1'b1;
            top_tx_data  = {1'b0, host_data};
          end
        end
        ST_TERM: begin
          if (!f_full) begin
            top_tx_write = 1'b1;
            top_tx_data  = spw_marker(eep_q | ~link_run);
          end
        end
        ST_DISCARD: host_ready = 1'b1;
        default: ;
      endcase
    end
  end

  assign pkt_count   = pkt_cnt_q;
  assign abort_count = abort_cnt_q;
  assign dbg_state_o = state_q;

`ifdef SPW_TX_TIMECODE_EN
  spw_timecode_sched #(
    .TIME_INIT (TIME_INIT)
  ) u_timecode (
    .clk_i        (CLOCK),
    .rst_ni       (RESETn),
    .tick_req_i   (tick_req),
    .ready_tick_i (top_tx_ready_tick),
    .link_run_i   (link_run),
    .tick_o       (top_tx_tick),
    .time_o       (top_tx_time)
  );
`else
  logic unused_timecode_in;
  assign unused_timecode_in = tick_req ^ top_tx_ready_tick;
  assign top_tx_tick        = 1'b0;
  assign top_tx_time        = 8'h00;
`endif

endmodule

// File: tb/tb_spw_tx_host_feeder.sv
// Bench for spw_tx_host_feeder: directed scenarios plus randomized packets
// checked against a packet-level model of the expected FIFO word stream.
module tb_spw_tx_host_feeder;
  import spw_tx_host_feeder_pkg::*;

  localparam int MAXL  = 4;
  localparam int TINIT = 63;
  localparam logic [8:0] EOP_W = 9'h100;
  localparam logic [8:0] EEP_W = 9'h101;

  logic        CLOCK = 1'b0;
  logic        RESETn;
  logic        host_valid;
  logic [7:0]  host_data;
  logic        host_last;
  logic        host_err;
  logic        host_ready;
  logic        link_run;
  logic        f_full;
  logic        top_tx_write;
  logic [8:0]  top_tx_data;
  logic        tick_req;
  logic        top_tx_ready_tick;
  logic        top_tx_tick;
  logic [7:0]  top_tx_time;
  logic [15:0] pkt_count;
  logic [15:0] abort_count;
  feeder_state_e dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int pkt_exp = 0;
  int abort_exp = 0;
  bit rand_full = 1'b0;
  logic [8:0] exp_q[$];
  logic [7:0] pkt_bytes[$];

  spw_tx_host_feeder #(
    .MAX_PKT_LEN (MAXL),
    .TIME_INIT   (TINIT)
  ) dut (
    .CLOCK             (CLOCK),
    .RESETn            (RESETn),
    .host_valid        (host_valid),
    .host_data         (host_data),
    .host_last         (host_last),
    .host_err          (host_err),
    .host_ready        (host_ready),
    .link_run          (link_run),
    .f_full            (f_full),
    .top_tx_write      (top_tx_write),
    .top_tx_data       (top_tx_data),
    .tick_req          (tick_req),
    .top_tx_ready_tick (top_tx_ready_tick),
    .top_tx_tick       (top_tx_tick),
    .top_tx_time       (top_tx_time),
    .pkt_count         (pkt_count),
    .abort_count       (abort_count),
    .dbg_state_o       (dbg_state)
  );

  // clock / reset
  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // scoreboard: every FIFO write must match the head of the expected queue
  always @(negedge CLOCK) begin
    if (RESETn === 1'b1 && top_tx_write === 1'b1) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_bad++;
        $error("FAIL write_unexpected: observed %03h expected no write", top_tx_data);
      end
      if (exp_q.size() != 0) check("write_data", 32'(top_tx_data), 32'(exp_q.pop_front()));
    end
  end

  // packet-level model: data bytes up to MAXL, then EOP/EEP, or forced EEP
  task automatic model_pkt(input int n, input bit err);
    for (int i = 0; i < n; i++)
      if (i < MAXL) exp_q.push_back({1'b0, pkt_bytes[i]});
    if (n > MAXL) exp_q.push_back(EEP_W);
    else          exp_q.push_back(err ? EEP_W : EOP_W);
    pkt_exp++;
  endtask

  task automatic step();
    @(posedge CLOCK); #1;
    if (rand_full) f_full = ($urandom_range(0, 3) == 0);
  endtask

  task automatic drive_beat(input logic [7:0] d, input logic last, input logic err);
    bit got;
    got = 1'b0;
    host_valid = 1'b1; host_data = d; host_last = last; host_err = err;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge CLOCK);
      got = host_ready;
      step();
    end
    check("beat_accept", 32'(got), 32'd1);
    host_valid = 1'b0; host_last = 1'b0; host_err = 1'b0;
  endtask

  task automatic send_pkt(input int n, input bit err, input bit gaps);
    model_pkt(n, err);
    for (int i = 0; i < n; i++) begin
      drive_beat(pkt_bytes[i], (i == n - 1), (i == n - 1) && err);
      if (gaps) repeat ($urandom_range(0, 2)) step();
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    repeat (2) step();
  endtask

  initial begin
    RESETn = 1'b0; host_valid = 1'b1; host_data = 8'hAA; host_last = 1'b0; host_err = 1'b0;
    link_run = 1'b1; f_full = 1'b0; tick_req = 1'b0; top_tx_ready_tick = 1'b0;

    // reset values, with a valid beat and a ready link presented
    repeat (3) @(negedge CLOCK);
    check("rst_ready", 32'(host_ready), 32'd0);
    check("rst_write", 32'(top_tx_write), 32'd0);
    check("rst_data", 32'(top_tx_data), 32'd0);
    check("rst_tick", 32'(top_tx_tick), 32'd0);
    check("rst_pkt", 32'(pkt_count), 32'd0);
    check("rst_abort", 32'(abort_count), 32'd0);
    @(posedge CLOCK); #1;
    host_valid = 1'b0; RESETn = 1'b1;
    repeat (2) step();

    // three-byte packet terminated by EOP
    pkt_bytes = '{8'h11, 8'h22, 8'h33};
    send_pkt(3, 1'b0, 1'b0);
    drain("pkt3");
    check("pkt3_count", 32'(pkt_count), 32'(pkt_exp));

    // FIFO full while the marker is due
    pkt_bytes = '{8'h5A};
    send_pkt(1, 1'b0, 1'b0);
    f_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLOCK);
      check("full_write", 32'(top_tx_write), 32'd0);
      check("full_ready", 32'(host_ready), 32'd0);
    end
    @(posedge CLOCK); #1;
    f_full = 1'b0;
    @(negedge CLOCK);
    check("eop_write", 32'(top_tx_write), 32'd1);
    check("eop_data", 32'(top_tx_data), 32'(EOP_W));
    drain("full");
    check("full_count", 32'(pkt_count), 32'(pkt_exp));

    // six bytes against a four-byte limit: forced EEP, tail consumed silently
    pkt_bytes = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};
    send_pkt(6, 1'b0, 1'b0);
    drain("ovf");
    check("ovf_count", 32'(pkt_count), 32'(pkt_exp));
    check("ovf_abort", 32'(abort_count), 32'(abort_exp));

    // exact-limit packet ends normally with an error marker
    pkt_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_pkt(4, 1'b1, 1'b0);
    drain("exact");

    // link lost after byte 2 of 5
    exp_q.push_back(9'h0D1);
    exp_q.push_back(9'h0D2);
    abort_exp++;
    drive_beat(8'hD1, 1'b0, 1'b0);
    drive_beat(8'hD2, 1'b0, 1'b0);
    link_run = 1'b0;
    @(negedge CLOCK);
    check("linkdown_ready", 32'(host_ready), 32'd0);
    @(posedge CLOCK); #1;
    f_full = 1'b1;
    @(negedge CLOCK);
    check("discard_ready", 32'(host_ready), 32'd1);
    drive_beat(8'hD3, 1'b0, 1'b0);
    drive_beat(8'hD4, 1'b0, 1'b0);
    drive_beat(8'hD5, 1'b1, 1'b0);
    f_full = 1'b0;
    link_run = 1'b1;
    drain("abort");
    check("abort_count", 32'(abort_count), 32'(abort_exp));
    check("abort_pkt", 32'(pkt_count), 32'(pkt_exp));

    // randomized packets with random FIFO back-pressure
    rand_full = 1'b1;
    for (int p = 0; p < 25; p++) begin
      int n;
      bit err;
      n = $urandom_range(1, 7);
      err = $urandom_range(0, 1);
      pkt_bytes = {};
      for (int i = 0; i < n; i++) pkt_bytes.push_back(8'($urandom_range(0, 255)));
      send_pkt(n, err, 1'b1);
    end
    rand_full = 1'b0;
    f_full = 1'b0;
    drain("rand");
    check("rand_pkt", 32'(pkt_count), 32'(pkt_exp));
    check("rand_abort", 32'(abort_count), 32'(abort_exp));

`ifdef SPW_TX_TIMECODE_EN
    begin
      logic [5:0] tc_model;
      tc_model = 6'(TINIT);
      tick_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge CLOCK);
        check("tc_blocked", 32'(top_tx_tick), 32'd0);
        step();
      end
      tick_req = 1'b0;
      top_tx_ready_tick = 1'b1;
      @(negedge CLOCK);
      check("tc_tick", 32'(top_tx_tick), 32'd1);
      check("tc_time", 32'(top_tx_time), 32'({2'b00, tc_model}));
      tc_model = tc_model + 6'd1;
      for (int i = 0; i < 3; i++) begin
        step();
        @(negedge CLOCK);
        check("tc_single", 32'(top_tx_tick), 32'd0);
        check("tc_wrap", 32'(top_tx_time), 32'({2'b00, tc_model}));
      end
      top_tx_ready_tick = 1'b0;
    end
`else
    tick_req = 1'b1;
    top_tx_ready_tick = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge CLOCK);
      check("tc_off_tick", 32'(top_tx_tick), 32'd0);
      check("tc_off_time", 32'(top_tx_time), 32'd0);
    end
    tick_req = 1'b0;
    top_tx_ready_tick = 1'b0;
`endif
    step();

    // reset in the middle of a packet
    exp_q.push_back(9'h0E1);
    exp_q.push_back(9'h0E2);
    drive_beat(8'hE1, 1'b0, 1'b0);
    drive_beat(8'hE2, 1'b0, 1'b0);
    host_valid = 1'b1; host_data = 8'hE3;
    RESETn = 1'b0;
    #1;
    check("rst2_ready", 32'(host_ready), 32'd0);
    check("rst2_write", 32'(top_tx_write), 32'd0);
    check("rst2_data", 32'(top_tx_data), 32'd0);
    check("rst2_tick", 32'(top_tx_tick), 32'd0);
    check("rst2_pkt", 32'(pkt_count), 32'd0);
    check("rst2_abort", 32'(abort_count), 32'd0);
    check("rst2_pending", 32'(exp_q.size()), 32'd0);
    pkt_exp = 0;
    abort_exp = 0;
    @(posedge CLOCK); #1;
    host_valid = 1'b0;
    RESETn = 1'b1;
    repeat (2) step();
    pkt_bytes = '{8'h77};
    send_pkt(1, 1'b0, 1'b0);
    drain("post_rst");
    check("post_rst_pkt", 32'(pkt_count), 32'(pkt_exp));
    check("post_rst_abort", 32'(abort_count), 32'(abort_exp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
